exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the five-stage MIPS pipeline, between decode (upstream) and memory (downstream). Latches one decoded instruction per handshake and selects the two ALU operands. It drives the `ALU` instance, detects arithmetic-overflow and address-alignment exceptions, and owns the HI/LO registers. It also issues the data-SRAM request with byte enables, so load data returns in the memory stage.

## Interface
- `DATA_WIDTH`, 32, datapath width; only 32 is supported.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ds_to_es_valid` in 1: decode holds a valid instruction.
- `es_allowin` out 1: stage can accept this cycle.
- `ds_pc` in 32: instruction PC.
- `ds_alu_op` in 4: ALU opcode (AND 0, OR 1, ADD 2, LUI 3, SLTU 4, SLL 5, SUB 6, SLT 7, NOR 9, XOR A, SRA B, SRL C).
- `ds_src1_is_sa` in 1: ALU A = zero-extended `ds_sa`, else `ds_rs_value`.
- `ds_src2_sel` in 2: ALU B selector.
  - 00 rt.
  - 01 sign-extended imm.
  - 10 zero-extended imm.
  - 11 constant 8 (link).
- `ds_rs_value`, `ds_rt_value` in 32: forwarded register operands.
- `ds_imm` in 16, `ds_sa` in 5: immediate and shift amount.
- `ds_mem_op` in 3: memory operation.
  - 000 none.
  - 001 LW, 010 LH, 011 LB.
  - 101 SW, 110 SH, 111 SB.
- `ds_dest` in 5: destination GPR; 0 means none.
- `ds_ov_trap` in 1: overflow traps (ADD/ADDI/SUB).
- `ds_hilo_op` in 2: 00 none, 01 MTHI, 10 MTLO, 11 MF (`ds_src1_is_sa`=1 selects HI, 0 selects LO).
- `ms_allowin` in 1: memory stage can accept.
- `es_to_ms_valid` out 1: stage output valid.
- `es_pc` out 32, `es_result` out 32, `es_dest` out 5, `es_mem_op` out 3, `es_ex` out 1, `es_excode` out 2 (01 overflow, 10 address error load, 11 address error store).
- `es_fwd_valid` out 1, `es_fwd_dest` out 5: bypass/hazard info to decode.
- `data_sram_en` out 1, `data_sram_wen` out 4, `data_sram_addr` out 32, `data_sram_wdata` out 32.

## Operation
- Stage register: `es_valid` plus the latched payload.
  - Payload loads when `ds_to_es_valid && es_allowin`.
  - `es_valid` loads `ds_to_es_valid` whenever `es_allowin` is high.
- Readiness: `es_ready_go` is always 1. `es_allowin = !es_valid || ms_allowin`. `es_to_ms_valid = es_valid`.
- `es_result`:
  - MF selects HI or LO.
  - Otherwise it is the ALU `Result` on the registered operands.
  - ALU `Zero` and `CarryOut` are unused.
- Overflow exception: when `ds_ov_trap` is set and ALU `Overflow` is 1, set `es_ex`=1 and `es_excode`=01.
- Memory address is the ALU result (decode supplies ADD). Alignment faults:
  - LH/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
  - Faulting loads get excode 10, faulting stores excode 11, both with `es_ex`=1.
- When `es_ex` is set: `es_dest` is forced to 0, no SRAM request is issued and there is no HI/LO write.
- Store enables and data:
  - SB: `wen` = 1<<addr[1:0], `wdata` = {4{rt[7:0]}}.
  - SH: `wen` = addr[1] ? 1100 : 0011, `wdata` = {2{rt[15:0]}}.
  - SW: `wen` = 1111, `wdata` = rt.
  - Loads: `wen` = 0000.
- `data_sram_en = es_valid && ms_allowin && mem_op≠none && !es_ex`, so exactly one request is issued per instruction.
- HI/LO update: MTHI/MTLO writes `rs` at `es_valid && ms_allowin && !es_ex`.
- Forwarding: `es_fwd_valid = es_valid`; `es_fwd_dest` = `es_dest` (already 0 on exception).

## Timing
- Reset: `es_valid`=0, HI=LO=0, payload=0.
  - Every output is 0 except `es_allowin`=1.
  - `data_sram_en`=0, `wen`=0000.
- Latency is 1 cycle: an instruction accepted at edge N is presented with `es_to_ms_valid` during cycle N+1.
- Stall: with `ms_allowin`=0 and `es_valid`=1, the payload, outputs and HI/LO hold, `es_allowin`=0, and SRAM enable is 0.
- Simultaneous accept and release: when `es_valid` and `ms_allowin` are both high, the old entry leaves and a new one enters in the same cycle with no bubble.
- Reset mid-stall discards the entry with no SRAM request and no HI/LO write.
- `es_ex` is registered-path combinational: valid in the same cycle as `es_to_ms_valid`.

## Structure
- Shared package `cpu_defs`:
  - ALU opcode constants.
  - `mem_op`, `hilo_op` and excode encodings.
  - `src2_sel` constants.
- Sub-modules:
  - Instantiates existing `ALU` once.
  - Store byte-enable/data generation as sub-module `store_align`.

## Test plan
- ADD A=0x7FFFFFFF, B=1, `ds_ov_trap`=1:
  - `es_ex`=1, excode 01, `es_dest`=0, no SRAM request.
  - Same with `ds_ov_trap`=0: result 0x80000000, no exception.
- SB, rs=0x1000, imm=3, rt=0x000000AB: addr 0x1003, `wen`=1000, `wdata`=0xABABABAB. SH at addr 0x1001: `es_ex`=1, excode 11, `data_sram_en`=0.
- SLL, sa=4, rt=0x0000000F, `ds_src1_is_sa`=1: result 0x000000F0. SRA, sa=4, rt=0x80000000: result 0xF8000000.
- MTHI rs=0x12345678, then MF with HI selected: `es_result`=0x12345678. Reset then MF: 0.
- Hold `ms_allowin`=0 for 3 cycles during an SW:
  - `es_allowin`=0 and outputs stable.
  - `data_sram_en` asserts exactly once, in the release cycle.
  - Back-to-back accepts proceed with no bubble.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared encodings for the execute stage: ALU opcodes, memory/HI-LO ops,
// exception codes, operand-B selectors and the latched stage payload.
package cpu_defs;

    localparam int DATA_W = 32;

    // ALU opcodes
    localparam logic [3:0] ALU_AND  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_LUI  = 4'h3;
    localparam logic [3:0] ALU_SLTU = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SUB  = 4'h6;
    localparam logic [3:0] ALU_SLT  = 4'h7;
    localparam logic [3:0] ALU_NOR  = 4'h9;
    localparam logic [3:0] ALU_XOR  = 4'hA;
    localparam logic [3:0] ALU_SRA  = 4'hB;
    localparam logic [3:0] ALU_SRL  = 4'hC;

    // Memory operations; bit 2 marks a store
    localparam logic [2:0] MEM_NONE = 3'b000;
    localparam logic [2:0] MEM_LW   = 3'b001;
    localparam logic [2:0] MEM_LH   = 3'b010;
    localparam logic [2:0] MEM_LB   = 3'b011;
    localparam logic [2:0] MEM_SW   = 3'b101;
    localparam logic [2:0] MEM_SH   = 3'b110;
    localparam logic [2:0] MEM_SB   = 3'b111;

    // HI/LO operations
    localparam logic [1:0] HILO_NONE = 2'b00;
    localparam logic [1:0] HILO_MTHI = 2'b01;
    localparam logic [1:0] HILO_MTLO = 2'b10;
    localparam logic [1:0] HILO_MF   = 2'b11;

    // Exception codes
    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_OV   = 2'b01;
    localparam logic [1:0] EXC_ADEL = 2'b10;
    localparam logic [1:0] EXC_ADES = 2'b11;

    // ALU operand-B selectors
    localparam logic [1:0] SRC2_RT   = 2'b00;
    localparam logic [1:0] SRC2_SIMM = 2'b01;
    localparam logic [1:0] SRC2_ZIMM = 2'b10;
    localparam logic [1:0] SRC2_LINK = 2'b11;

    // Decoded instruction as held in the stage register
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu_op;
        logic        src1_is_sa;
        logic [1:0]  src2_sel;
        logic [31:0] rs_value;
        logic [31:0] rt_value;
        logic [15:0] imm;
        logic [4:0]  sa;
        logic [2:0]  mem_op;
        logic [4:0]  dest;
        logic        ov_trap;
        logic [1:0]  hilo_op;
    } es_payload_t;

    // True when the access width demands alignment the address lacks
    function automatic logic addr_misaligned(input logic [2:0] mem_op,
                                             input logic [1:0] addr_lo);
        logic bad;
        case (mem_op)
            MEM_LW, MEM_SW: bad = (addr_lo != 2'b00);
            MEM_LH, MEM_SH: bad = addr_lo[0];
            default:        bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational MIPS ALU: logic, add/sub with signed overflow, compares,
// LUI and shifts (shift amount taken from A[4:0], shifted value is B).
module ALU
    import cpu_defs::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [3:0]            ALUop,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero,
    output logic [DATA_WIDTH-1:0] Result
);

    logic [DATA_WIDTH:0] sum_s;
    logic [DATA_WIDTH:0] diff_s;

    assign sum_s  = {1'b0, A} + {1'b0, B};
    assign diff_s = {1'b0, A} - {1'b0, B};

    // Opcode decode and result/flag generation
    always_comb begin
        Result   = '0;
        Overflow = 1'b0;
        CarryOut = 1'b0;
        case (ALUop)
            ALU_AND:  Result = A & B;
            ALU_OR:   Result = A | B;
            ALU_ADD: begin
                Result   = sum_s[DATA_WIDTH-1:0];
                CarryOut = sum_s[DATA_WIDTH];
                Overflow = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) &&
                           (sum_s[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
            end
            ALU_LUI:  Result = {B[15:0], 16'h0000};
            ALU_SLTU: Result = {{(DATA_WIDTH-1){1'b0}}, diff_s[DATA_WIDTH]};
            ALU_SLL:  Result = B << A[4:0];
            ALU_SUB: begin
                Result   = diff_s[DATA_WIDTH-1:0];
                CarryOut = diff_s[DATA_WIDTH];
                Overflow = (A[DATA_WIDTH-1] != B[DATA_WIDTH-1]) &&
                           (diff_s[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
            end
            ALU_SLT:  Result = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_NOR:  Result = ~(A | B);
            ALU_XOR:  Result = A ^ B;
            ALU_SRA:  Result = $signed(B) >>> A[4:0];
            ALU_SRL:  Result = B >> A[4:0];
            default:  Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/store_align.sv
// Store byte-enable and write-data replication for SB/SH/SW.
// Loads and non-memory ops produce no enables and zero data.
module store_align
    import cpu_defs::*;
(
    input  logic [2:0]  mem_op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rt_value_i,
    output logic [3:0]  wen_o,
    output logic [31:0] wdata_o
);

    // Lane selection and data replication per store width
    always_comb begin
        wen_o   = 4'b0000;
        wdata_o = 32'h0000_0000;
        case (mem_op_i)
            MEM_SB: begin
                wen_o   = 4'b0001 << addr_lo_i;
                wdata_o = {4{rt_value_i[7:0]}};
            end
            MEM_SH: begin
                wen_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{rt_value_i[15:0]}};
            end
            MEM_SW: begin
                wen_o   = 4'b1111;
                wdata_o = rt_value_i;
            end
            default: begin
                wen_o   = 4'b0000;
                wdata_o = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches one decoded instruction per handshake, runs the ALU
// on the registered operands, flags overflow/alignment exceptions, owns HI/LO
// and issues the data-SRAM request so load data returns in the memory stage.
module exe_stage
    import cpu_defs::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ds_to_es_valid,
    output logic                  es_allowin,
    input  logic [DATA_WIDTH-1:0] ds_pc,
    input  logic [3:0]            ds_alu_op,
    input  logic                  ds_src1_is_sa,
    input  logic [1:0]            ds_src2_sel,
    input  logic [DATA_WIDTH-1:0] ds_rs_value,
    input  logic [DATA_WIDTH-1:0] ds_rt_value,
    input  logic [15:0]           ds_imm,
    input  logic [4:0]            ds_sa,
    input  logic [2:0]            ds_mem_op,
    input  logic [4:0]            ds_dest,
    input  logic                  ds_ov_trap,
    input  logic [1:0]            ds_hilo_op,
    input  logic                  ms_allowin,
    output logic                  es_to_ms_valid,
    output logic [DATA_WIDTH-1:0] es_pc,
    output logic [DATA_WIDTH-1:0] es_result,
    output logic [4:0]            es_dest,
    output logic [2:0]            es_mem_op,
    output logic                  es_ex,
    output logic [1:0]            es_excode,
    output logic                  es_fwd_valid,
    output logic [4:0]            es_fwd_dest,
    output logic                  data_sram_en,
    output logic [3:0]            data_sram_wen,
    output logic [DATA_WIDTH-1:0] data_sram_addr,
    output logic [DATA_WIDTH-1:0] data_sram_wdata
);

    es_payload_t           payload_q, payload_d;
    logic                  es_valid_q, es_valid_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;

    logic [DATA_WIDTH-1:0] alu_a_s;
    logic [DATA_WIDTH-1:0] alu_b_s;
    logic [DATA_WIDTH-1:0] alu_result_s;
    logic                  alu_overflow_s;
    logic                  alu_zero_unused_s;
    logic                  alu_carry_unused_s;
    logic                  ex_s;
    logic [1:0]            excode_s;
    logic                  release_s;

    // es_ready_go is constant 1, so the stage frees whenever downstream accepts
    assign es_allowin = !es_valid_q || ms_allowin;
    assign release_s  = es_valid_q && ms_allowin;

    // Next-state for the valid bit and the instruction payload
    always_comb begin
        es_valid_d = es_valid_q;
        payload_d  = payload_q;
        if (es_allowin) begin
            es_valid_d = ds_to_es_valid;
        end else begin
            es_valid_d = es_valid_q;
        end
        if (ds_to_es_valid && es_allowin) begin
            payload_d.pc         = ds_pc;
            payload_d.alu_op     = ds_alu_op;
            payload_d.src1_is_sa = ds_src1_is_sa;
            payload_d.src2_sel   = ds_src2_sel;
            payload_d.rs_value   = ds_rs_value;
            payload_d.rt_value   = ds_rt_value;
            payload_d.imm        = ds_imm;
            payload_d.sa         = ds_sa;
            payload_d.mem_op     = ds_mem_op;
            payload_d.dest       = ds_dest;
            payload_d.ov_trap    = ds_ov_trap;
            payload_d.hilo_op    = ds_hilo_op;
        end else begin
            payload_d = payload_q;
        end
    end

    // Operand selection from the registered payload
    always_comb begin
        alu_a_s = payload_q.src1_is_sa ? {27'd0, payload_q.sa} : payload_q.rs_value;
        case (payload_q.src2_sel)
            SRC2_RT:   alu_b_s = payload_q.rt_value;
            SRC2_SIMM: alu_b_s = {{16{payload_q.imm[15]}}, payload_q.imm};
            SRC2_ZIMM: alu_b_s = {16'h0000, payload_q.imm};
            SRC2_LINK: alu_b_s = 32'd8;
            default:   alu_b_s = payload_q.rt_value;
        endcase
    end

    ALU #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .A        (alu_a_s),
        .B        (alu_b_s),
        .ALUop    (payload_q.alu_op),
        .Overflow (alu_overflow_s),
        .CarryOut (alu_carry_unused_s),
        .Zero     (alu_zero_unused_s),
        .Result   (alu_result_s)
    );

    // Exception detection; overflow takes precedence over alignment
    always_comb begin
        if (payload_q.ov_trap && alu_overflow_s) begin
            ex_s     = 1'b1;
            excode_s = EXC_OV;
        end else if (addr_misaligned(payload_q.mem_op, alu_result_s[1:0])) begin
            ex_s     = 1'b1;
            excode_s = payload_q.mem_op[2] ? EXC_ADES : EXC_ADEL;
        end else begin
            ex_s     = 1'b0;
            excode_s = EXC_NONE;
        end
    end

    // HI/LO writes happen only as an unfaulted MTHI/MTLO leaves the stage
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (release_s && !ex_s) begin
            case (payload_q.hilo_op)
                HILO_MTHI: hi_d = payload_q.rs_value;
                HILO_MTLO: lo_d = payload_q.rs_value;
                default: begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            endcase
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
    end

    // Stage, payload and HI/LO registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            es_valid_q <= 1'b0;
            payload_q  <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            payload_q  <= payload_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    store_align u_store_align (
        .mem_op_i   (payload_q.mem_op),
        .addr_lo_i  (alu_result_s[1:0]),
        .rt_value_i (payload_q.rt_value),
        .wen_o      (data_sram_wen),
        .wdata_o    (data_sram_wdata)
    );

    // MF reads HI when src1_is_sa is set, LO otherwise
    always_comb begin
        if (payload_q.hilo_op == HILO_MF) begin
            es_result = payload_q.src1_is_sa ? hi_q : lo_q;
        end else begin
            es_result = alu_result_s;
        end
    end

    assign es_to_ms_valid = es_valid_q;
    assign es_pc          = payload_q.pc;
    assign es_mem_op      = payload_q.mem_op;
    assign es_ex          = ex_s;
    assign es_excode      = excode_s;
    assign es_dest        = ex_s ? 5'd0 : payload_q.dest;
    assign es_fwd_valid   = es_valid_q;
    assign es_fwd_dest    = es_dest;
    assign data_sram_addr = alu_result_s;
    // One request per instruction: only in the cycle it hands over downstream
    assign data_sram_en   = release_s && (payload_q.mem_op != MEM_NONE) && !ex_s;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases with literal expectations
// followed by randomized traffic compared every cycle against a behavioural model.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ds_to_es_valid;
    logic        es_allowin;
    logic [31:0] ds_pc;
    logic [3:0]  ds_alu_op;
    logic        ds_src1_is_sa;
    logic [1:0]  ds_src2_sel;
    logic [31:0] ds_rs_value;
    logic [31:0] ds_rt_value;
    logic [15:0] ds_imm;
    logic [4:0]  ds_sa;
    logic [2:0]  ds_mem_op;
    logic [4:0]  ds_dest;
    logic        ds_ov_trap;
    logic [1:0]  ds_hilo_op;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [31:0] es_pc;
    logic [31:0] es_result;
    logic [4:0]  es_dest;
    logic [2:0]  es_mem_op;
    logic        es_ex;
    logic [1:0]  es_excode;
    logic        es_fwd_valid;
    logic [4:0]  es_fwd_dest;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;

    always #5 clk = ~clk;

    exe_stage #(.DATA_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .ds_to_es_valid  (ds_to_es_valid),
        .es_allowin      (es_allowin),
        .ds_pc           (ds_pc),
        .ds_alu_op       (ds_alu_op),
        .ds_src1_is_sa   (ds_src1_is_sa),
        .ds_src2_sel     (ds_src2_sel),
        .ds_rs_value     (ds_rs_value),
        .ds_rt_value     (ds_rt_value),
        .ds_imm          (ds_imm),
        .ds_sa           (ds_sa),
        .ds_mem_op       (ds_mem_op),
        .ds_dest         (ds_dest),
        .ds_ov_trap      (ds_ov_trap),
        .ds_hilo_op      (ds_hilo_op),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_pc           (es_pc),
        .es_result       (es_result),
        .es_dest         (es_dest),
        .es_mem_op       (es_mem_op),
        .es_ex           (es_ex),
        .es_excode       (es_excode),
        .es_fwd_valid    (es_fwd_valid),
        .es_fwd_dest     (es_fwd_dest),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  op;
        logic        s1sa;
        logic [1:0]  s2;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [4:0]  sa;
        logic [2:0]  mop;
        logic [4:0]  dest;
        logic        ovt;
        logic [1:0]  hop;
    } ins_t;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_valid;
    ins_t        m_ins;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    logic [3:0] op_list [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC};
    logic [2:0] mop_list [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic ins_t mk(input logic [3:0] op, input logic s1sa, input logic [1:0] s2,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [15:0] imm, input logic [4:0] sa,
                                input logic [2:0] mop, input logic [4:0] dest,
                                input logic ovt, input logic [1:0] hop, input logic [31:0] pc);
        ins_t i;
        i.pc = pc; i.op = op; i.s1sa = s1sa; i.s2 = s2; i.rs = rs; i.rt = rt;
        i.imm = imm; i.sa = sa; i.mop = mop; i.dest = dest; i.ovt = ovt; i.hop = hop;
        return i;
    endfunction

    task automatic drive(input ins_t i);
        ds_pc = i.pc; ds_alu_op = i.op; ds_src1_is_sa = i.s1sa; ds_src2_sel = i.s2;
        ds_rs_value = i.rs; ds_rt_value = i.rt; ds_imm = i.imm; ds_sa = i.sa;
        ds_mem_op = i.mop; ds_dest = i.dest; ds_ov_trap = i.ovt; ds_hilo_op = i.hop;
    endtask

    function automatic ins_t cur_ins();
        return mk(ds_alu_op, ds_src1_is_sa, ds_src2_sel, ds_rs_value, ds_rt_value,
                  ds_imm, ds_sa, ds_mem_op, ds_dest, ds_ov_trap, ds_hilo_op, ds_pc);
    endfunction

    // What an instruction in the stage must present, from the ISA rules
    function automatic void model_out(input ins_t e, input logic [31:0] hi, input logic [31:0] lo,
                                      output logic [31:0] res, output logic [31:0] addr,
                                      output logic [31:0] wdata, output logic [3:0] wen,
                                      output logic ex, output logic [1:0] code);
        logic [31:0] a, b, r;
        longint      wide;
        bit          ov, bad;
        a = e.s1sa ? {27'd0, e.sa} : e.rs;
        case (e.s2)
            2'd0:    b = e.rt;
            2'd1:    b = {{16{e.imm[15]}}, e.imm};
            2'd2:    b = {16'd0, e.imm};
            default: b = 32'd8;
        endcase
        ov = 1'b0;
        case (e.op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin
                wide = longint'($signed(a)) + longint'($signed(b));
                r = wide[31:0];
                ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'h3: r = b * 32'd65536;
            4'h4: r = (a < b) ? 32'd1 : 32'd0;
            4'h5: r = b << a[4:0];
            4'h6: begin
                wide = longint'($signed(a)) - longint'($signed(b));
                r = wide[31:0];
                ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'h7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h9: r = ~(a | b);
            4'hA: r = a ^ b;
            4'hB: r = $signed(b) >>> a[4:0];
            4'hC: r = b >> a[4:0];
            default: r = 32'd0;
        endcase
        addr = r;
        res  = (e.hop == 2'b11) ? (e.s1sa ? hi : lo) : r;
        bad  = ((e.mop == 3'b010 || e.mop == 3'b110) && (r % 2 != 0)) ||
               ((e.mop == 3'b001 || e.mop == 3'b101) && (r % 4 != 0));
        if (e.ovt && ov) begin
            ex = 1'b1; code = 2'b01;
        end else if (bad) begin
            ex = 1'b1; code = e.mop[2] ? 2'b11 : 2'b10;
        end else begin
            ex = 1'b0; code = 2'b00;
        end
        wen = 4'b0000;
        wdata = 32'd0;
        case (e.mop)
            3'b111: begin wen[r[1:0]] = 1'b1; wdata = {24'd0, e.rt[7:0]} * 32'h0101_0101; end
            3'b110: begin wen = (r % 4 >= 2) ? 4'b1100 : 4'b0011;
                          wdata = {16'd0, e.rt[15:0]} * 32'h0001_0001; end
            3'b101: begin wen = 4'b1111; wdata = e.rt; end
            default: begin wen = 4'b0000; wdata = 32'd0; end
        endcase
    endfunction

    // Per-cycle comparison of every DUT output against the model
    task automatic check_model();
        logic [31:0] res, addr, wdata;
        logic [3:0]  wen;
        logic        ex;
        logic [1:0]  code;
        logic [4:0]  dst;
        model_out(m_ins, m_hi, m_lo, res, addr, wdata, wen, ex, code);
        dst = ex ? 5'd0 : m_ins.dest;
        chk("m_allowin",  es_allowin,      !m_valid || ms_allowin);
        chk("m_valid",    es_to_ms_valid,  m_valid);
        chk("m_pc",       es_pc,           m_ins.pc);
        chk("m_result",   es_result,       res);
        chk("m_dest",     es_dest,         dst);
        chk("m_memop",    es_mem_op,       m_ins.mop);
        chk("m_ex",       es_ex,           ex);
        chk("m_excode",   es_excode,       code);
        chk("m_fwdvalid", es_fwd_valid,    m_valid);
        chk("m_fwddest",  es_fwd_dest,     dst);
        chk("m_sram_en",  data_sram_en,    m_valid && ms_allowin && (m_ins.mop != 3'd0) && !ex);
        chk("m_wen",      data_sram_wen,   wen);
        chk("m_addr",     data_sram_addr,  addr);
        chk("m_wdata",    data_sram_wdata, wdata);
    endtask

    // Model state advance at a clock edge, using the inputs held across it
    task automatic model_update();
        logic [31:0] res, addr, wdata;
        logic [3:0]  wen;
        logic        ex;
        logic [1:0]  code;
        bit          allow;
        if (rst) begin
            m_valid = 1'b0; m_ins = '0; m_hi = 32'd0; m_lo = 32'd0;
        end else begin
            model_out(m_ins, m_hi, m_lo, res, addr, wdata, wen, ex, code);
            allow = !m_valid || ms_allowin;
            if (m_valid && ms_allowin && !ex) begin
                if (m_ins.hop == 2'b01) m_hi = m_ins.rs;
                if (m_ins.hop == 2'b10) m_lo = m_ins.rs;
            end
            if (allow && ds_to_es_valid) m_ins = cur_ins();
            if (allow) m_valid = ds_to_es_valid;
        end
    endtask

    // One clock: compare, cross the edge, advance the model, return at negedge
    task automatic cycle();
        #1;
        check_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic issue(input ins_t i);
        drive(i);
        ds_to_es_valid = 1'b1;
        ms_allowin = 1'b1;
        cycle();
        ds_to_es_valid = 1'b0;
    endtask

    function automatic ins_t rand_ins();
        ins_t  i;
        int    kind;
        i = '0;
        i.pc = $urandom; i.dest = 5'($urandom); i.sa = 5'($urandom);
        i.rt = $urandom; i.imm = 16'($urandom);
        case ($urandom_range(0, 3))
            0: i.rs = 32'h7fff_ffff - $urandom_range(0, 3);
            1: i.rs = 32'h8000_0000 + $urandom_range(0, 3);
            default: i.rs = $urandom;
        endcase
        kind = $urandom_range(0, 9);
        if (kind <= 5) begin
            i.op = op_list[$urandom_range(0, 11)];
            i.s1sa = 1'($urandom); i.s2 = 2'($urandom);
            i.ovt = (i.op == 4'h2 || i.op == 4'h6) ? 1'($urandom) : 1'b0;
        end else if (kind <= 7) begin
            i.op = 4'h2; i.s2 = 2'b01; i.s1sa = 1'b0;
            i.imm = 16'($urandom_range(0, 7));
            i.mop = mop_list[$urandom_range(0, 5)];
        end else if (kind == 8) begin
            i.hop = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        end else begin
            i.hop = 2'b11; i.s1sa = 1'($urandom);
        end
        return i;
    endfunction

    initial begin
        rst = 1'b1;
        ds_to_es_valid = 1'b0;
        ms_allowin = 1'b1;
        drive('0);
        @(posedge clk);
        model_update();
        @(negedge clk);
        cycle();
        rst = 1'b0;

        // Reset state
        #1;
        chk("rst_allowin", es_allowin, 32'd1);
        chk("rst_valid",   es_to_ms_valid, 32'd0);
        chk("rst_result",  es_result, 32'd0);
        chk("rst_pc",      es_pc, 32'd0);
        chk("rst_en",      data_sram_en, 32'd0);
        chk("rst_wen",     data_sram_wen, 32'd0);
        chk("rst_wdata",   data_sram_wdata, 32'd0);

        // ADD overflow, trapping then non-trapping
        issue(mk(4'h2, 1'b0, 2'b00, 32'h7fff_ffff, 32'd1, 16'd0, 5'd0, 3'd0, 5'd5, 1'b1, 2'd0, 32'h100));
        #1;
        chk("ov_valid",  es_to_ms_valid, 32'd1);
        chk("ov_ex",     es_ex, 32'd1);
        chk("ov_code",   es_excode, 32'd1);
        chk("ov_dest",   es_dest, 32'd0);
        chk("ov_en",     data_sram_en, 32'd0);
        issue(mk(4'h2, 1'b0, 2'b00, 32'h7fff_ffff, 32'd1, 16'd0, 5'd0, 3'd0, 5'd5, 1'b0, 2'd0, 32'h104));
        #1;
        chk("add_result", es_result, 32'h8000_0000);
        chk("add_ex",     es_ex, 32'd0);
        chk("add_dest",   es_dest, 32'd5);

        // SB byte lane and misaligned SH
        issue(mk(4'h2, 1'b0, 2'b01, 32'h1000, 32'h0000_00AB, 16'd3, 5'd0, 3'b111, 5'd0, 1'b0, 2'd0, 32'h108));
        #1;
        chk("sb_addr",  data_sram_addr, 32'h1003);
        chk("sb_wen",   data_sram_wen, 32'h8);
        chk("sb_wdata", data_sram_wdata, 32'hABAB_ABAB);
        chk("sb_en",    data_sram_en, 32'd1);
        issue(mk(4'h2, 1'b0, 2'b01, 32'h1000, 32'h0000_1234, 16'd1, 5'd0, 3'b110, 5'd0, 1'b0, 2'd0, 32'h10c));
        #1;
        chk("sh_ex",   es_ex, 32'd1);
        chk("sh_code", es_excode, 32'd3);
        chk("sh_en",   data_sram_en, 32'd0);

        // Shifts by sa
        issue(mk(4'h5, 1'b1, 2'b00, 32'd0, 32'h0000_000F, 16'd0, 5'd4, 3'd0, 5'd2, 1'b0, 2'd0, 32'h110));
        #1;
        chk("sll_result", es_result, 32'h0000_00F0);
        issue(mk(4'hB, 1'b1, 2'b00, 32'd0, 32'h8000_0000, 16'd0, 5'd4, 3'd0, 5'd2, 1'b0, 2'd0, 32'h114));
        #1;
        chk("sra_result", es_result, 32'hF800_0000);

        // MTHI then MF back to back
        issue(mk(4'h0, 1'b0, 2'b00, 32'h1234_5678, 32'd0, 16'd0, 5'd0, 3'd0, 5'd0, 1'b0, 2'b01, 32'h118));
        issue(mk(4'h0, 1'b1, 2'b00, 32'd0, 32'd0, 16'd0, 5'd0, 3'd0, 5'd3, 1'b0, 2'b11, 32'h11c));
        #1;
        chk("mfhi_result", es_result, 32'h1234_5678);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        issue(mk(4'h0, 1'b1, 2'b00, 32'd0, 32'd0, 16'd0, 5'd0, 3'd0, 5'd3, 1'b0, 2'b11, 32'h120));
        #1;
        chk("mf_after_rst", es_result, 32'd0);

        // SW held for three cycles, with the next instruction waiting
        issue(mk(4'h2, 1'b0, 2'b01, 32'h2000, 32'hDEAD_BEEF, 16'd4, 5'd0, 3'b101, 5'd0, 1'b0, 2'd0, 32'h200));
        drive(mk(4'h1, 1'b0, 2'b00, 32'h5, 32'hA, 16'd0, 5'd0, 3'd0, 5'd9, 1'b0, 2'd0, 32'h204));
        ds_to_es_valid = 1'b1;
        ms_allowin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_allowin", es_allowin, 32'd0);
            chk("stall_en",      data_sram_en, 32'd0);
            chk("stall_pc",      es_pc, 32'h200);
            chk("stall_valid",   es_to_ms_valid, 32'd1);
            cycle();
        end
        ms_allowin = 1'b1;
        #1;
        chk("rel_en",    data_sram_en, 32'd1);
        chk("rel_wen",   data_sram_wen, 32'hF);
        chk("rel_addr",  data_sram_addr, 32'h2004);
        chk("rel_wdata", data_sram_wdata, 32'hDEAD_BEEF);
        chk("rel_allow", es_allowin, 32'd1);
        cycle();
        ds_to_es_valid = 1'b0;
        #1;
        chk("next_pc",     es_pc, 32'h204);
        chk("next_valid",  es_to_ms_valid, 32'd1);
        chk("next_result", es_result, 32'hF);
        chk("next_en",     data_sram_en, 32'd0);
        cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            ms_allowin = ($urandom_range(0, 3) != 0);
            ds_to_es_valid = ($urandom_range(0, 3) != 0);
            drive(rand_ins());
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
